// File: rtl/id_head_tail_alloc.sv
// Outstanding-transaction ID table: one entry per in-flight ID with a
// saturating count; requests allocate/increment, last response beats release.
module id_head_tail_alloc #(
    parameter int NumIds   = 4,
    parameter int IdWidth  = 4,
    parameter int CntWidth = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    input  logic [IdWidth-1:0] req_id_i,
    output logic               req_ready_o,
    input  logic               rsp_valid_i,
    input  logic [IdWidth-1:0] rsp_id_i,
    input  logic               rsp_last_i,
    output logic               rsp_err_o,
    output logic               full_o,
    output logic               busy_o
);

    localparam logic [CntWidth-1:0] MaxCnt = '1;

    logic [NumIds-1:0]   free_q;
    logic [IdWidth-1:0]  id_q  [NumIds];
    logic [CntWidth-1:0] cnt_q [NumIds];
    logic                rsp_err_q;

    logic [NumIds-1:0] req_hit;
    logic [NumIds-1:0] rsp_hit;
    logic [NumIds-1:0] at_max;
    logic [NumIds-1:0] alloc_sel;
    logic [NumIds-1:0] inc;
    logic [NumIds-1:0] dec;
    logic              req_match;
    logic              rsp_match;
    logic              req_fire;

    always_comb begin
        req_hit = '0;
        rsp_hit = '0;
        at_max  = '0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            req_hit[i] = !free_q[i] && (id_q[i] == req_id_i);
            rsp_hit[i] = !free_q[i] && (id_q[i] == rsp_id_i);
            at_max[i]  = (cnt_q[i] == MaxCnt);
        end
    end

    // Lowest set bit of the pre-edge free vector; entries freed this cycle are not visible here.
    assign alloc_sel = free_q & (~free_q + NumIds'(1));

    assign req_match   = |req_hit;
    assign rsp_match   = |rsp_hit;
    assign full_o      = &(~free_q);
    assign busy_o      = |(~free_q);
    assign req_ready_o = req_match ? ~|(req_hit & at_max) : ~full_o;
    assign req_fire    = req_valid_i & req_ready_o;
    assign rsp_err_o   = rsp_err_q;

    always_comb begin
        inc = '0;
        dec = '0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            inc[i] = req_fire && (req_hit[i] || (!req_match && alloc_sel[i]));
            dec[i] = rsp_valid_i && rsp_last_i && rsp_hit[i];
        end
    end

    // Simultaneous increment and decrement of one entry cancel, so it stays allocated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            free_q    <= '1;
            rsp_err_q <= 1'b0;
            for (int unsigned i = 0; i < NumIds; i++) begin
                id_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            rsp_err_q <= rsp_valid_i && !rsp_match;
            for (int unsigned i = 0; i < NumIds; i++) begin
                if (inc[i] && !dec[i]) begin
                    free_q[i] <= 1'b0;
                    id_q[i]   <= req_id_i;
                    cnt_q[i]  <= cnt_q[i] + 1'b1;
                end else if (dec[i] && !inc[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                    if (cnt_q[i] == CntWidth'(1)) begin
                        free_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_id_head_tail_alloc.sv
// Randomized bench for id_head_tail_alloc against an ID->count map model,
// with directed sequences for the documented corner cases.
module tb_id_head_tail_alloc;

    localparam int NUM  = 4;
    localparam int IW   = 4;
    localparam int CW   = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic [IW-1:0] req_id_i = '0;
    logic          req_ready_o;
    logic          rsp_valid_i = 1'b0;
    logic [IW-1:0] rsp_id_i = '0;
    logic          rsp_last_i = 1'b0;
    logic          rsp_err_o;
    logic          full_o;
    logic          busy_o;

    id_head_tail_alloc #(
        .NumIds  (NUM),
        .IdWidth (IW),
        .CntWidth(CW)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_valid_i(req_valid_i),
        .req_id_i   (req_id_i),
        .req_ready_o(req_ready_o),
        .rsp_valid_i(rsp_valid_i),
        .rsp_id_i   (rsp_id_i),
        .rsp_last_i (rsp_last_i),
        .rsp_err_o  (rsp_err_o),
        .full_o     (full_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Model: outstanding transaction count per live ID.
    int m[int];
    bit exp_err = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready(int id);
        if (m.exists(id)) return m[id] < MAXC;
        return m.num() < NUM;
    endfunction

    task automatic model_step(input bit rv, input int rid, input bit sv, input int sid, input bit sl);
        bit rfire;
        bit smatch;
        rfire  = rv && model_ready(rid);
        smatch = sv && m.exists(sid);
        exp_err = sv && !smatch;
        if (rfire && smatch && sl && rid == sid) return;
        if (smatch && sl) begin
            m[sid] = m[sid] - 1;
            if (m[sid] == 0) m.delete(sid);
        end
        if (rfire) begin
            if (m.exists(rid)) m[rid] = m[rid] + 1;
            else m[rid] = 1;
        end
    endtask

    task automatic drive(input bit rv, input int rid, input bit sv, input int sid, input bit sl);
        @(negedge clk_i);
        req_valid_i = rv;
        req_id_i    = IW'(rid);
        rsp_valid_i = sv;
        rsp_id_i    = IW'(sid);
        rsp_last_i  = sl;
        #1;
        check_eq("req_ready", {31'd0, req_ready_o}, {31'd0, model_ready(rid)});
        check_eq("full", {31'd0, full_o}, {31'd0, m.num() == NUM});
        check_eq("busy", {31'd0, busy_o}, {31'd0, m.num() != 0});
        check_eq("rsp_err", {31'd0, rsp_err_o}, {31'd0, exp_err});
        model_step(rv, rid, sv, sid, sl);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        #3;
        rst_ni = 1'b0;
        m.delete();
        exp_err = 1'b0;
        #1;
        check_eq("rst_err", {31'd0, rsp_err_o}, 32'd0);
        check_eq("rst_full", {31'd0, full_o}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_ready", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_last_i  = 1'b0;
        @(negedge clk_i);
        #2;
        rst_ni = 1'b1;
    endtask

    initial begin
        do_reset();
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // Fill the table with four distinct IDs
        drive(1, 1, 0, 0, 0);
        drive(1, 2, 0, 0, 0);
        drive(1, 3, 0, 0, 0);
        drive(1, 4, 0, 0, 0);
        drive(1, 5, 0, 0, 0);
        check_eq("full_new_id_blocked", {31'd0, req_ready_o}, 32'd0);
        drive(1, 2, 0, 0, 0);
        check_eq("full_known_id_ready", {31'd0, req_ready_o}, 32'd1);

        // Unknown ID beat errors once; non-last beat on a live ID is silent
        drive(0, 0, 1, 9, 0);
        drive(0, 0, 1, 3, 0);
        check_eq("err_after_unknown", {31'd0, rsp_err_o}, 32'd1);
        drive(0, 0, 0, 0, 0);
        check_eq("no_err_nonlast", {31'd0, rsp_err_o}, 32'd0);

        // Freed entry is not reusable in the same cycle
        drive(1, 7, 1, 3, 1);
        check_eq("freed_not_reusable", {31'd0, req_ready_o}, 32'd0);
        drive(1, 7, 0, 0, 0);
        check_eq("freed_reused", {31'd0, req_ready_o}, 32'd1);

        // Same-ID req and last response at cnt==1 keeps the entry
        drive(1, 7, 1, 7, 1);
        drive(0, 7, 0, 0, 0);
        check_eq("same_id_busy", {31'd0, busy_o}, 32'd1);
        check_eq("same_id_full", {31'd0, full_o}, 32'd1);

        // Saturate ID 6 and check the blocked-increment / decrement case
        drive(0, 0, 1, 1, 1);
        for (int k = 0; k < MAXC; k++) drive(1, 6, 0, 0, 0);
        drive(1, 6, 0, 0, 0);
        check_eq("sat_blocked", {31'd0, req_ready_o}, 32'd0);
        drive(1, 6, 1, 6, 1);
        drive(1, 6, 0, 0, 0);
        check_eq("sat_after_dec", {31'd0, req_ready_o}, 32'd1);
        drive(0, 6, 0, 0, 0);

        for (int c = 0; c < 3000; c++) begin
            bit rv;
            bit sv;
            bit sl;
            int rid;
            int sid;
            if (c % 750 == 749) do_reset();
            rv  = ($urandom_range(0, 9) < 6);
            rid = $urandom_range(0, 5);
            sv  = ($urandom_range(0, 9) < 4);
            sid = $urandom_range(0, 6);
            sl  = ($urandom_range(0, 9) < 6);
            drive(rv, rid, sv, sid, sl);
        end

        // Reset while an error pulse is pending leaves no residual pulse
        drive(0, 0, 1, 15, 1);
        drive(0, 0, 0, 0, 0);
        do_reset();
        drive(0, 0, 0, 0, 0);
        check_eq("post_reset_no_err", {31'd0, rsp_err_o}, 32'd0);
        drive(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_head_tail_alloc.md
ID_HEAD_TAIL_ALLOC -- requirements
Module: id_head_tail_alloc

Interface
REQ-001 SHALL have parameter NumIds, default 4: number of ID table entries, >= 2.
REQ-002 SHALL have parameter IdWidth, default 4: width of request/response IDs.
REQ-003 SHALL have parameter CntWidth, default 3: width of per-entry outstanding counter; max count MaxCnt = 2^CntWidth-1.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  1  new transaction issued with req_id_i.
REQ-007 SHALL have port req_id_i  input  IdWidth  ID of new transaction.
REQ-008 SHALL have port req_ready_o  output  1  table can accept req_id_i this cycle.
REQ-009 SHALL have port rsp_valid_i  input  1  response beat observed with rsp_id_i.
REQ-010 SHALL have port rsp_id_i  input  IdWidth  ID of response beat.
REQ-011 SHALL have port rsp_last_i  input  1  beat completes one transaction.
REQ-012 SHALL have port rsp_err_o  output  1  registered one-cycle pulse: previous-cycle response beat matched no allocated entry.
REQ-013 SHALL have port full_o  output  1  no free entry.
REQ-014 SHALL have port busy_o  output  1  at least one entry allocated.

Function
REQ-015 SHALL hold per entry: free (1b), id (IdWidth), cnt (CntWidth); allocated entries satisfy cnt >= 1.
REQ-016 SHALL match entry i to an ID only when !free[i] && id[i] == that ID; at most one entry matches any ID.
REQ-017 SHALL compute req_ready_o combinationally from registered state: (req match && cnt != MaxCnt) || (no req match && !full_o); independent of rsp_* and of req_valid_i.
REQ-018 SHALL on req handshake (req_valid_i && req_ready_o) with match: cnt += 1 at next edge.
REQ-019 SHALL on req handshake without match: allocate lowest-index free entry, set free=0, id=req_id_i, cnt=1 at next edge.
REQ-020 SHALL treat rsp_valid_i as always accepted (no back-pressure).
REQ-021 SHALL on rsp_valid_i && rsp_last_i with match: cnt -= 1; if result is 0, set free=1 and cnt=0 at next edge.
REQ-022 SHALL ignore non-last matching beats (no state change).
REQ-023 SHALL on rsp_valid_i with no match (last or not): leave state unchanged and assert rsp_err_o for exactly the next cycle.
REQ-024 SHALL on simultaneous req handshake and rsp-last of the same matching ID: keep cnt unchanged and entry allocated, including cnt==1 and cnt==MaxCnt.
REQ-025 SHALL on simultaneous req handshake and rsp-last of different IDs: apply both updates independently in one edge.
REQ-026 SHALL select allocation from pre-edge free vector; an entry freed this cycle is not reusable until next cycle; req_id_i matching an entry being freed this cycle counts as match (REQ-024 applies).
REQ-027 SHALL never let cnt wrap: increments gated by req_ready_o; decrement only on matched entries with cnt >= 1.
REQ-028 SHALL derive full_o = &(~free) and busy_o = |(~free) from registered state (combinational, no added latency).

Reset
REQ-029 SHALL on rst_ni low, asynchronously: all free=1, id=0, cnt=0, rsp_err_o=0; hence full_o=0, busy_o=0, req_ready_o=1.
REQ-030 SHALL on reset mid-operation discard all outstanding entries; no residual rsp_err_o pulse after release.

Verification
REQ-031 Reset, no stimulus -> full_o=0, busy_o=0, req_ready_o=1, rsp_err_o=0.
REQ-032 NumIds=4: reqs IDs 1,2,3,4 on consecutive cycles -> entries 0..3 allocated, full_o=1; req ID 5 -> req_ready_o=0; req ID 2 -> req_ready_o=1, entry1 cnt=2.
REQ-033 CntWidth=3: 7 reqs ID 6 -> cnt=7, req_ready_o=0 for ID 6; same cycle req ID 6 + rsp_last ID 6 with ready=0 -> only decrement, cnt=6.
REQ-034 Entry ID 3 cnt=1: req ID 3 and rsp_last ID 3 same cycle -> entry stays allocated, cnt=1; busy_o stays 1.
REQ-035 rsp_valid_i, rsp_id_i=9 with no entry 9 -> rsp_err_o=1 next cycle only, state unchanged; non-last beat ID 3 (allocated) -> no change, no error.
REQ-036 Full table, rsp_last frees entry 2 while req new ID 7 -> req_ready_o=0 that cycle; next cycle ID 7 allocated into entry 2.
